// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point adder/subtractor: operand capture, unpack/align,
// add, normalise/pack; truncating rounding, full-pipeline stall on back-pressure.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             negate,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out,
  output logic [TAG_W-1:0] out_tag,
  output logic [2:0]       flags
);

  localparam int AW  = MAN_W + 4;   // hidden + mantissa + guard/round/sticky
  localparam int SW  = MAN_W + 5;   // aligned width plus carry
  localparam int XW  = EXP_W + 2;   // signed headroom for normalised exponent
  localparam int LZW = $clog2(SW);

  logic stall, adv;
  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // ---------------- operand capture ----------------
  logic             v0, neg0;
  logic [W-1:0]     a0, b0;
  logic [TAG_W-1:0] tag0;

  always_ff @(posedge clk) begin
    if (reset) begin
      v0   <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      neg0 <= 1'b0;
      tag0 <= '0;
    end else if (adv) begin
      v0   <= in_valid;
      a0   <= a;
      b0   <= b;
      neg0 <= negate;
      tag0 <= in_tag;
    end
  end

  // ---------------- unpack / swap / align ----------------
  logic             sa, sb, za, zb, a_big, nan_c;
  logic [EXP_W-1:0] ea, eb, exp_l, exp_s, diff;
  logic [MAN_W:0]   ma, mb, mant_l, mant_s;
  logic [AW-1:0]    ext_s, sh_s, mask_s, al_s;

  always_comb begin
    sa     = a0[W-1];
    sb     = b0[W-1] ^ neg0;
    ea     = a0[W-2:MAN_W];
    eb     = b0[W-2:MAN_W];
    za     = (ea == '0);
    zb     = (eb == '0);
    nan_c  = (ea == {EXP_W{1'b1}}) | (eb == {EXP_W{1'b1}});
    ma     = za ? '0 : {1'b1, a0[MAN_W-1:0]};
    mb     = zb ? '0 : {1'b1, b0[MAN_W-1:0]};
    // flushed operands compare as zero magnitude
    a_big  = {ea, za ? {MAN_W{1'b0}} : a0[MAN_W-1:0]} >=
             {eb, zb ? {MAN_W{1'b0}} : b0[MAN_W-1:0]};
    exp_l  = a_big ? ea : eb;
    exp_s  = a_big ? eb : ea;
    mant_l = a_big ? ma : mb;
    mant_s = a_big ? mb : ma;
    diff   = exp_l - exp_s;
    ext_s  = {mant_s, 3'b000};
    sh_s   = '0;
    mask_s = '0;
    if (diff >= EXP_W'(AW)) begin
      al_s = {{(AW-1){1'b0}}, |mant_s};
    end else begin
      sh_s   = ext_s >> diff;
      mask_s = ~({AW{1'b1}} << diff);
      al_s   = sh_s | {{(AW-1){1'b0}}, |(ext_s & mask_s)};
    end
  end

  logic             v1, nan1, sign1, same1;
  logic [EXP_W-1:0] exp1;
  logic [AW-1:0]    al_l1, al_s1;
  logic [TAG_W-1:0] tag1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      nan1  <= 1'b0;
      sign1 <= 1'b0;
      same1 <= 1'b0;
      exp1  <= '0;
      al_l1 <= '0;
      al_s1 <= '0;
      tag1  <= '0;
    end else if (adv) begin
      v1    <= v0;
      nan1  <= nan_c;
      sign1 <= a_big ? sa : sb;
      same1 <= (sa == sb);
      exp1  <= exp_l;
      al_l1 <= {mant_l, 3'b000};
      al_s1 <= al_s;
      tag1  <= tag0;
    end
  end

  // ---------------- add / subtract ----------------
  logic [SW-1:0] sum_c;

  always_comb begin
    if (same1) sum_c = {1'b0, al_l1} + {1'b0, al_s1};
    else       sum_c = {1'b0, al_l1} - {1'b0, al_s1};
  end

  logic             v2, nan2, sign2;
  logic [EXP_W-1:0] exp2;
  logic [SW-1:0]    sum2;
  logic [TAG_W-1:0] tag2;

  always_ff @(posedge clk) begin
    if (reset) begin
      v2    <= 1'b0;
      nan2  <= 1'b0;
      sign2 <= 1'b0;
      exp2  <= '0;
      sum2  <= '0;
      tag2  <= '0;
    end else if (adv) begin
      v2    <= v1;
      nan2  <= nan1;
      sign2 <= sign1;
      exp2  <= exp1;
      sum2  <= sum_c;
      tag2  <= tag1;
    end
  end

  // ---------------- normalise / pack ----------------
  logic [LZW-1:0]   lz;
  logic [AW-1:0]    shl;
  logic [MAN_W-1:0] man_n;
  logic [XW-1:0]    exp_n;
  logic [W-1:0]     res;
  logic [2:0]       flg;

  always_comb begin
    lz = LZW'(AW);
    for (int i = 0; i < AW; i++) begin
      if (sum2[i]) lz = LZW'(AW - 1 - i);
    end
    shl = sum2[AW-1:0] << lz;
    if (sum2[SW-1]) begin
      man_n = sum2[AW-1:4];
      exp_n = {2'b00, exp2} + XW'(1);
    end else begin
      man_n = shl[AW-2:3];
      exp_n = {2'b00, exp2} - {{(XW-LZW){1'b0}}, lz};
    end

    res = {sign2, exp_n[EXP_W-1:0], man_n};
    flg = 3'b000;
    if (nan2) begin
      res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      flg = 3'b100;
    end else if (sum2 == '0) begin
      res = '0;
    end else if (!exp_n[XW-1] && exp_n >= {2'b00, {EXP_W{1'b1}}}) begin
      res = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = 3'b010;
    end else if (exp_n[XW-1] || exp_n == '0) begin
      res = {sign2, {(W-1){1'b0}}};
      flg = 3'b001;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_tag   <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out       <= res;
      out_tag   <= tag2;
      flags     <= flg;
    end
  end

endmodule

// File: doc/fp_addsub_pipe.md
# fp_addsub_pipe

Parametrised, three-stage pipelined IEEE-754-style floating-point adder/subtractor with valid/ready flow control, tag passthrough and exception flags. It is the next generation of the team's single-cycle float adder: width is generic, one operation is accepted per clock, and results are exactly truncated (round toward zero) using guard/round/sticky bits. It sits between the operand-issue logic and the result writeback queue of the FP datapath.

## Interface
- EXP_W, 8, exponent width.
- MAN_W, 23, stored mantissa width (hidden bit excluded); W = 1+EXP_W+MAN_W.
- TAG_W, 4, width of opaque tag carried alongside each operation.
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept this cycle.
- a  input  W  first operand.
- b  input  W  second operand.
- negate  input  1  1: compute a-b; 0: a+b.
- in_tag  input  TAG_W  tag for this operation.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out  output  W  result.
- out_tag  output  TAG_W  tag of result.
- flags  output  3  {invalid, overflow, underflow} for result.

## Operation
- Transfer occurs on an edge where valid && ready (each side).
- Stage 1 (unpack/swap/align): effective sign of b = b.sign ^ negate. Exponent 0 → operand is zero (denormals flushed). Larger operand chosen by {exp,man} magnitude compare; smaller mantissa (hidden bit restored) right-shifted by exponent difference into MAN_W+4 bits with 3 extra bits (guard, round, sticky); all shifted-out ones OR into sticky; difference ≥ MAN_W+4 → smaller collapses to sticky only.
- Stage 2 (add): same effective signs → add magnitudes; else subtract smaller from larger (never negative). Sum width MAN_W+5. Result sign = sign of larger operand.
- Stage 3 (normalise/pack): carry out → shift right 1 (sticky kept), exp+1; else leading-zero count lz, shift left lz, exp-lz. Drop G/R/S (truncate). Exact zero magnitude → +0 (all bits 0), no flag.
- Exceptions, priority order: any operand exp all-ones → out = {0, all-ones exp, MSB of man =1, rest 0} (quiet NaN), invalid=1. Result exp ≥ 2^EXP_W−1 → ±infinity (exp all ones, man 0), overflow=1. Result exp ≤ 0 → signed zero, underflow=1.
- Tag and flags travel with data; out_tag equals in_tag of the same operation.

## Timing
- Latency 3: accepted at edge N → out_valid, out, out_tag, flags valid after edge N+3.
- Throughput 1 operation/clk with out_ready held high.
- Stall: stall = out_valid && !out_ready. in_ready = !stall (combinational). While stall, all three stages hold; no operation lost or duplicated. out/out_tag/flags stable while out_valid && !out_ready.
- Bubbles are not collapsed; full-pipeline stall only.
- Reset: all stage valid bits, out_valid, out, out_tag, flags → 0 on the edge where reset is high. Inputs ignored while reset high. Reset mid-operation discards all in-flight operations; none emerges afterward.
- Simultaneous accept at input and output during a non-stall cycle: both occur; pipeline shifts.

## Test plan
- a=0x3F800000, b=0x3F800000, negate=0 → out=0x40000000, flags=0, 3 cycles after accept, tag preserved.
- a=0x40400000 (3.0), b=0x40A00000 (5.0), negate=1 → out=0xC0000000 (−2.0); a=b=0x3F800000, negate=1 → out=0x00000000.
- a=0x7F7FFFFF, b=0x7F7FFFFF → out=0x7F800000, overflow=1; a=0x7F800000, b=0x3F800000 → out=0x7FC00000, invalid=1.
- a=0x3F800000, b=0x33800000 (2^−24), negate=1 → out=0x3F7FFFFF (sticky-correct truncation).
- Back-to-back 8 operations with tags 0..7, out_ready toggled pseudo-randomly → results in order, tags 0..7, none dropped/duplicated, outputs stable during stall.
- Reset asserted one cycle with 2 operations in flight → out_valid 0 next cycle, no stale result ever appears; new op after reset completes normally.
